// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads instruction words from RAM and hands them to execute over valid/ready.
// Define HALT_DETECT_EN to stop fetching after a halt opcode (ir_out[30:27] == 4'b0001) is consumed.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100,
    parameter int PC_STEP = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ir_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
);
    typedef enum logic [1:0] {S_ADDR, S_DATA, S_HOLD, S_HALT} state_t;
    state_t state, state_d;
    logic started, hs, halt_op, fetch;
    logic [ADDR_WIDTH-1:0] pc;

    assign mem_we = 1'b0;
    assign hs = ir_valid && ir_ready;
    // started holds the FSM for one edge after rst_n rises, giving a synchronous release
    assign fetch = state == S_ADDR && started;
`ifdef HALT_DETECT_EN
    assign halt_op = ir_out[30:27] == 4'b0001;
    assign halted = state == S_HALT;
`else
    assign halt_op = 1'b0;
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d = state;
        if (redirect_valid) state_d = S_ADDR;
        else if (fetch) state_d = S_DATA;
        else if (state == S_DATA) state_d = S_HOLD;
        else if (state == S_HOLD && hs) state_d = halt_op ? S_HALT : S_ADDR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_ADDR;
            started  <= 1'b0;
            pc       <= RESET_PC;
            mem_addr <= '0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            ir_out   <= '0;
            pc_out   <= '0;
            ir_valid <= 1'b0;
        end else begin
            state   <= state_d;
            started <= 1'b1;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                mem_cs   <= 1'b0;
                mem_oe   <= 1'b0;
                ir_valid <= 1'b0;
            end else begin
                mem_cs <= fetch;
                mem_oe <= fetch;
                if (fetch) mem_addr <= pc;
                if (state == S_DATA) begin
                    ir_out   <= mem_rdata;
                    pc_out   <= pc;
                    pc       <= pc + ADDR_WIDTH'(PC_STEP);
                    ir_valid <= 1'b1;
                end else if (hs) begin
                    ir_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus a randomized ready/redirect run checked against a
// transaction-level model (expected fetch address sequence and RAM contents).
module tb_instr_fetch_unit;
    logic        clk = 0, rst_n = 0;
    logic [13:0] mem_addr, pc_out, redirect_pc = '0;
    logic        mem_cs, mem_we, mem_oe, ir_valid, halted;
    logic        ir_ready = 0, redirect_valid = 0;
    logic [31:0] mem_rdata, ir_out;
    logic [31:0] mem [0:16383];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;
    // the MAR inside the DUT is the RAM's address register, so data follows it within the cycle
    assign mem_rdata = (mem_cs && mem_oe) ? mem[mem_addr] : 32'hDEAD_BEEF;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_oe(mem_oe), .mem_rdata(mem_rdata), .ir_out(ir_out), .pc_out(pc_out),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted)
    );

    task automatic do_reset(input bit rdy);
        @(negedge clk);
        rst_n = 0;
        redirect_valid = 0;
        ir_ready = rdy;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_valid(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge clk);
            ok = ir_valid;
        end
    endtask

    task automatic redirect_to(input logic [13:0] t);
        @(negedge clk);
        redirect_valid = 1;
        redirect_pc = t;
        @(negedge clk);
        redirect_valid = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 0;
        ir_ready = 1;
        @(negedge clk);
        tests++;
        if ({ir_valid, mem_cs, mem_oe, mem_we, halted} !== 5'b0 || mem_addr !== 14'h0 || ir_out !== 32'h0 || pc_out !== 14'h0) begin
            fails++;
            $display("FAIL reset_state: valid=%b cs=%b oe=%b we=%b halted=%b addr=%h ir=%h pc=%h, want all 0",
                     ir_valid, mem_cs, mem_oe, mem_we, halted, mem_addr, ir_out, pc_out);
        end
        rst_n = 1;
        @(negedge clk);
        tests++;
        if (ir_valid !== 0 || mem_cs !== 0) begin
            fails++;
            $display("FAIL edge1: valid=%b cs=%b, want 0 0", ir_valid, mem_cs);
        end
        @(negedge clk);
        tests++;
        if (ir_valid !== 0 || mem_cs !== 1 || mem_oe !== 1 || mem_addr !== 14'h100) begin
            fails++;
            $display("FAIL edge2: valid=%b cs=%b oe=%b addr=%h, want 0 1 1 100", ir_valid, mem_cs, mem_oe, mem_addr);
        end
        @(negedge clk);
        tests++;
        if (ir_valid !== 1 || ir_out !== 32'h1000011E || pc_out !== 14'h100 || mem_cs !== 0) begin
            fails++;
            $display("FAIL first_word: valid=%b ir=%h pc=%h cs=%b, want 1 1000011e 100 0", ir_valid, ir_out, pc_out, mem_cs);
        end
    endtask

    task automatic test_throughput;
        @(negedge clk);
        tests++;
        if (ir_valid !== 0) begin
            fails++;
            $display("FAIL consumed: valid=%b, want 0", ir_valid);
        end
        @(negedge clk);
        tests++;
        if (mem_cs !== 1 || mem_addr !== 14'h102) begin
            fails++;
            $display("FAIL second_addr: cs=%b addr=%h, want 1 102", mem_cs, mem_addr);
        end
        @(negedge clk);
        tests++;
        if (ir_valid !== 1 || ir_out !== 32'h00000120 || pc_out !== 14'h102) begin
            fails++;
            $display("FAIL second_word: valid=%b ir=%h pc=%h, want 1 00000120 102", ir_valid, ir_out, pc_out);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        do_reset(0);
        wait_valid(6, ok);
        tests++;
        if (!ok || ir_out !== 32'h1000011E || pc_out !== 14'h100) begin
            fails++;
            $display("FAIL bp_first: seen=%b ir=%h pc=%h, want 1 1000011e 100", ok, ir_out, pc_out);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (ir_valid !== 1 || ir_out !== 32'h1000011E || pc_out !== 14'h100 || mem_cs !== 0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: valid=%b ir=%h pc=%h cs=%b, want 1 1000011e 100 0", i, ir_valid, ir_out, pc_out, mem_cs);
            end
        end
        ir_ready = 1;
        wait_valid(6, ok);
        tests++;
        if (!ok || ir_out !== 32'h00000120 || pc_out !== 14'h102) begin
            fails++;
            $display("FAIL bp_resume: seen=%b ir=%h pc=%h, want 1 00000120 102", ok, ir_out, pc_out);
        end
    endtask

    task automatic test_redirect;
        bit ok, found;
        do_reset(1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = mem_cs && mem_addr == 14'h104;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL redir_reach_104: cs=%b addr=%h, want 1 104", mem_cs, mem_addr);
        end
        redirect_valid = 1;
        redirect_pc = 14'h116;
        @(negedge clk);
        redirect_valid = 0;
        tests++;
        if (ir_valid !== 0 || mem_cs !== 0) begin
            fails++;
            $display("FAIL redir_flush: valid=%b cs=%b, want 0 0", ir_valid, mem_cs);
        end
        wait_valid(6, ok);
        tests++;
        if (!ok || pc_out !== 14'h116 || ir_out !== mem[14'h116]) begin
            fails++;
            $display("FAIL redir_target: seen=%b pc=%h ir=%h, want 1 116 %h", ok, pc_out, ir_out, mem[14'h116]);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        redirect_to(14'h3FFE);
        wait_valid(6, ok);
        tests++;
        if (!ok || pc_out !== 14'h3FFE || ir_out !== mem[14'h3FFE]) begin
            fails++;
            $display("FAIL wrap_top: seen=%b pc=%h ir=%h, want 1 3ffe %h", ok, pc_out, ir_out, mem[14'h3FFE]);
        end
        wait_valid(6, ok);
        tests++;
        if (!ok || pc_out !== 14'h0000 || ir_out !== mem[0]) begin
            fails++;
            $display("FAIL wrap_zero: seen=%b pc=%h ir=%h, want 1 0000 %h", ok, pc_out, ir_out, mem[0]);
        end
    endtask

    task automatic test_halt;
        bit ok, bad;
        mem[14'h118] = 32'h08000000;
        ir_ready = 1;
        redirect_to(14'h118);
        wait_valid(6, ok);
        tests++;
        if (!ok || pc_out !== 14'h118 || ir_out !== 32'h08000000) begin
            fails++;
            $display("FAIL halt_word: seen=%b pc=%h ir=%h, want 1 118 08000000", ok, pc_out, ir_out);
        end
`ifdef HALT_DETECT_EN
        @(negedge clk);
        tests++;
        if (halted !== 1 || ir_valid !== 0) begin
            fails++;
            $display("FAIL halt_enter: halted=%b valid=%b, want 1 0", halted, ir_valid);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bad |= mem_cs || ir_valid || !halted;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL halt_idle: activity seen=%b, want 0", bad);
        end
        redirect_to(14'h100);
        tests++;
        if (halted !== 0) begin
            fails++;
            $display("FAIL halt_exit: halted=%b, want 0", halted);
        end
        wait_valid(6, ok);
        tests++;
        if (!ok || pc_out !== 14'h100) begin
            fails++;
            $display("FAIL halt_resume: seen=%b pc=%h, want 1 100", ok, pc_out);
        end
`else
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bad |= halted;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL halt_tied: halted seen=%b, want 0", bad);
        end
        redirect_to(14'h11A);
        wait_valid(6, ok);
        tests++;
        if (!ok || pc_out !== 14'h11A) begin
            fails++;
            $display("FAIL no_halt_continue: seen=%b pc=%h, want 1 11a", ok, pc_out);
        end
`endif
        mem[14'h118] = 32'h0;
    endtask

    task automatic test_reset_mid_fetch;
        bit found;
        int n;
        do_reset(1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = mem_cs;
        end
        #2 rst_n = 0;
        #1;
        tests++;
        if (!found || ir_valid !== 0 || mem_cs !== 0 || mem_oe !== 0 || mem_addr !== 14'h0) begin
            fails++;
            $display("FAIL reset_mid_data: in_data=%b valid=%b cs=%b oe=%b addr=%h, want 1 0 0 0 0", found, ir_valid, mem_cs, mem_oe, mem_addr);
        end
        @(negedge clk);
        rst_n = 1;
        ir_ready = 0;
        n = 0;
        while (!ir_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 3 || pc_out !== 14'h100) begin
            fails++;
            $display("FAIL reset_mid_restart: edges=%0d pc=%h, want 3 100", n, pc_out);
        end
        #2 rst_n = 0;
        #1;
        tests++;
        if (ir_valid !== 0 || ir_out !== 32'h0 || pc_out !== 14'h0) begin
            fails++;
            $display("FAIL reset_mid_hold: valid=%b ir=%h pc=%h, want 0 0 0", ir_valid, ir_out, pc_out);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random;
        logic [13:0] exp_pc, prev_pc, tgt;
        logic [31:0] prev_ir;
        bit prev_valid, rdy, redir;
        int words;
        do_reset(0);
        exp_pc = 14'h100;
        prev_valid = 0;
        prev_pc = '0;
        prev_ir = '0;
        rdy = 0;
        redir = 0;
        tgt = '0;
        words = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (prev_valid && rdy) begin
                tests++;
                words++;
                if (prev_pc !== exp_pc || prev_ir !== mem[prev_pc]) begin
                    fails++;
                    $display("FAIL rand_word[%0d]: pc=%h ir=%h, want %h %h", c, prev_pc, prev_ir, exp_pc, mem[exp_pc]);
                end
                exp_pc = exp_pc + 14'd2;
            end
            if (redir) begin
                exp_pc = tgt;
                tests++;
                if (ir_valid !== 0 || mem_cs !== 0) begin
                    fails++;
                    $display("FAIL rand_flush[%0d]: valid=%b cs=%b, want 0 0", c, ir_valid, mem_cs);
                end
            end else if (prev_valid && !rdy) begin
                tests++;
                if (ir_valid !== 1 || ir_out !== prev_ir || pc_out !== prev_pc) begin
                    fails++;
                    $display("FAIL rand_stall[%0d]: valid=%b ir=%h pc=%h, want 1 %h %h", c, ir_valid, ir_out, pc_out, prev_ir, prev_pc);
                end
            end
            if (mem_we !== 0 || halted !== 0 || mem_oe !== mem_cs) begin
                tests++;
                fails++;
                $display("FAIL rand_ctrl[%0d]: we=%b halted=%b oe=%b cs=%b, want 0 0 oe==cs", c, mem_we, halted, mem_oe, mem_cs);
            end
            prev_valid = ir_valid;
            prev_pc = pc_out;
            prev_ir = ir_out;
            rdy = $urandom_range(0, 1) == 1;
            redir = $urandom_range(0, 11) == 0;
            tgt = 14'($urandom_range(0, 16383));
            ir_ready = rdy;
            redirect_valid = redir;
            redirect_pc = tgt;
        end
        redirect_valid = 0;
        tests++;
        if (words < 50) begin
            fails++;
            $display("FAIL rand_progress: words=%0d, want >= 50", words);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom & 32'h87FF_FFFF;
        mem[14'h100] = 32'h1000011E;
        mem[14'h102] = 32'h00000120;
        test_reset;
        test_throughput;
        test_backpressure;
        test_redirect;
        test_wrap;
        test_halt;
        test_reset_mid_fetch;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
